// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the eight-requester round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ        = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned MAX_HOLD_DEF = 16;
  localparam int unsigned HC_W_DEF     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters and the arbiter.
interface rr_arbiter_8_if;
  import rr_arb_pkg::*;

  logic             arb_en;
  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_change;

  modport master (
    output arb_en, req,
    input  gnt_idx, gnt_valid, gnt_change
  );

  modport slave (
    input  arb_en, req,
    output gnt_idx, gnt_valid, gnt_change
  );

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first requester after ptr, wrapping, ending at ptr.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  assign any = |req;

  // Scan ptr+1 .. ptr+8 (mod 8); the 3-bit add provides the wrap.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered grant index and hold limit.
// Optional feature: define RR_ARB_PRIO0_EN to make requester 0 preempt other holders.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned HC_W     = HC_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_8_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             gnt_change_q, gnt_change_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;

  logic [IDX_W-1:0] resume_ptr_c;
  logic [IDX_W-1:0] pick_ptr_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_any_c;
  logic             release_c;

`ifdef RR_ARB_PRIO0_EN
  logic             pre_q, pre_d;
  logic [IDX_W-1:0] pre_ptr_q, pre_ptr_d;

  // After a preemption by requester 0, fairness resumes from the preempted holder.
  assign resume_ptr_c = pre_q ? pre_ptr_q : gnt_idx_q;
`else
  assign resume_ptr_c = gnt_idx_q;
`endif

  assign pick_ptr_c = (state_q == GRANT) ? resume_ptr_c : last_ptr_q;

  assign release_c = !bus.req[gnt_idx_q] ||
                     ((MAX_HOLD != 0) && (hold_cnt_q == HC_W'(MAX_HOLD)));

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (pick_ptr_c),
    .idx (pick_idx_c),
    .any (pick_any_c)
  );

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_idx_q    <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_change_q <= 1'b0;
      hold_cnt_q   <= '0;
      last_ptr_q   <= IDX_W'(N_REQ - 1);
`ifdef RR_ARB_PRIO0_EN
      pre_q        <= 1'b0;
      pre_ptr_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_change_q <= gnt_change_d;
      hold_cnt_q   <= hold_cnt_d;
      last_ptr_q   <= last_ptr_d;
`ifdef RR_ARB_PRIO0_EN
      pre_q        <= pre_d;
      pre_ptr_q    <= pre_ptr_d;
`endif
    end
  end

  // Next-state and next-grant decision.
  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_change_d = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    last_ptr_d   = last_ptr_q;
`ifdef RR_ARB_PRIO0_EN
    pre_d        = pre_q;
    pre_ptr_d    = pre_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        if (bus.arb_en && pick_any_c) begin
          state_d      = GRANT;
          gnt_idx_d    = pick_idx_c;
          gnt_valid_d  = 1'b1;
          gnt_change_d = 1'b1;
          hold_cnt_d   = HC_W'(1);
        end
      end
      GRANT: begin
        if (!bus.arb_en) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          last_ptr_d  = resume_ptr_c;
`ifdef RR_ARB_PRIO0_EN
          pre_d       = 1'b0;
        end else if (bus.req[0] && (gnt_idx_q != '0)) begin
          gnt_idx_d    = '0;
          gnt_change_d = 1'b1;
          hold_cnt_d   = HC_W'(1);
          pre_d        = 1'b1;
          pre_ptr_d    = gnt_idx_q;
`endif
        end else if (release_c) begin
          last_ptr_d = resume_ptr_c;
`ifdef RR_ARB_PRIO0_EN
          pre_d      = 1'b0;
`endif
          if (pick_any_c) begin
            gnt_idx_d    = pick_idx_c;
            gnt_change_d = 1'b1;
            hold_cnt_d   = HC_W'(1);
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_change = gnt_change_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: default hold limit, MAX_HOLD=4 and MAX_HOLD=3 instances.
module tb_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_8_if d_if ();
  rr_arbiter_8_if h4_if ();
  rr_arbiter_8_if h3_if ();

  rr_arbiter_8 u_d (.clk(clk), .rst(rst), .bus(d_if));
  rr_arbiter_8 #(.MAX_HOLD(4)) u_h4 (.clk(clk), .rst(rst), .bus(h4_if));
  rr_arbiter_8 #(.MAX_HOLD(3)) u_h3 (.clk(clk), .rst(rst), .bus(h3_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] g_idx, input logic g_val,
                           input logic g_chg, input logic [2:0] e_idx, input logic e_val,
                           input logic e_chg);
    chk({tag, ".idx"}, 8'(g_idx), 8'(e_idx));
    chk({tag, ".valid"}, 8'(g_val), 8'(e_val));
    chk({tag, ".change"}, 8'(g_chg), 8'(e_chg));
  endtask

  logic [7:0] ff_req;
  int         ff_first;
  int         ff_cnt;

  initial begin
    rst = 1'b1;
    d_if.arb_en = 1'b0;  d_if.req = 8'h00;
    h4_if.arb_en = 1'b0; h4_if.req = 8'h00;
    h3_if.arb_en = 1'b0; h3_if.req = 8'h00;
    tick();
    tick();
    chk_grant("reset_d", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b0, 1'b0);
    chk_grant("reset_h4", h4_if.gnt_idx, h4_if.gnt_valid, h4_if.gnt_change, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single requester 0: one-cycle latency then hold.
    d_if.arb_en = 1'b1; d_if.req = 8'h01;
    tick();
    chk_grant("t1_grant", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant("t1_hold", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b1, 1'b0);
    end

    // Release to IDLE keeps index; then grant 5; then 5 drops with req 0 and 3 -> wrap to 0.
    d_if.req = 8'h00;
    tick();
    chk_grant("t3_idle", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b0, 1'b0);
    d_if.req = 8'h20;
    tick();
    chk_grant("t3_g5", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd5, 1'b1, 1'b1);
    d_if.req = 8'h09;
    tick();
    chk_grant("t3_wrap0", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b1, 1'b1);

    // Hand off 0 -> 4, disable for one cycle, re-enable with 4 and 5 requesting.
    d_if.req = 8'h10;
    tick();
    chk_grant("t5_g4", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd4, 1'b1, 1'b1);
    tick();
    chk_grant("t5_hold4", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd4, 1'b1, 1'b0);
    d_if.arb_en = 1'b0;
    tick();
    chk_grant("t5_dis", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd4, 1'b0, 1'b0);
    d_if.arb_en = 1'b1; d_if.req = 8'h30;
    tick();
    chk_grant("t5_reen", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd5, 1'b1, 1'b1);

    // All requesting, MAX_HOLD=4: each index holds exactly 4 cycles, 7 wraps to the start.
`ifdef RR_ARB_PRIO0_EN
    ff_req = 8'hFE; ff_first = 1; ff_cnt = 7;
`else
    ff_req = 8'hFF; ff_first = 0; ff_cnt = 8;
`endif
    h4_if.arb_en = 1'b1; h4_if.req = ff_req;
    for (int g = 0; g <= ff_cnt; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_grant("t2_rr", h4_if.gnt_idx, h4_if.gnt_valid, h4_if.gnt_change,
                  3'(ff_first + (g % ff_cnt)), 1'b1, 1'(c == 0));
      end
    end

    // Single requester 2, MAX_HOLD=3: re-granted every third cycle.
    h3_if.arb_en = 1'b1; h3_if.req = 8'h04;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_grant("t4_regrant", h3_if.gnt_idx, h3_if.gnt_valid, h3_if.gnt_change,
                3'd2, 1'b1, 1'(k % 3 == 0));
    end

    // Reset mid-tenure (with arb_en low on one instance): reset wins everywhere.
    d_if.req = 8'h30;
    h3_if.arb_en = 1'b0;
    rst = 1'b1;
    tick();
    chk_grant("t5_rst_d", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b0, 1'b0);
    chk_grant("t5_rst_h3", h3_if.gnt_idx, h3_if.gnt_valid, h3_if.gnt_change, 3'd0, 1'b0, 1'b0);
    chk_grant("t5_rst_h4", h4_if.gnt_idx, h4_if.gnt_valid, h4_if.gnt_change, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_grant("t5_post_rst", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd4, 1'b1, 1'b1);

    // Holder 4 drops while 6 requests: search from 4 finds 6.
    d_if.req = 8'h40;
    tick();
    chk_grant("t6_g6", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd6, 1'b1, 1'b1);
`ifdef RR_ARB_PRIO0_EN
    d_if.req = 8'h41;
    tick();
    chk_grant("t6_preempt", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd0, 1'b1, 1'b1);
    d_if.req = 8'hC0;
    tick();
    chk_grant("t6_resume7", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd7, 1'b1, 1'b1);
`else
    d_if.req = 8'h41;
    tick();
    chk_grant("t6_no_preempt", d_if.gnt_idx, d_if.gnt_valid, d_if.gnt_change, 3'd6, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
